// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: FSM encoding, round constants, initial hash and
// the bitwise round functions used by the compression datapath.
package sha256_pkg;

  localparam int ROUNDS = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_ADD   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Index 0 sits in the most significant word so {H0..H7} maps straight onto DIGEST.
  localparam logic [0:7][31:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_compress_if.sv
// Bus between the SHA-256 compression engine and its controller / schedule stage.
interface sha256_compress_if;
  // START is a request qualified only while the engine is idle: it is taken on
  // the first rising edge where the engine is in IDLE and START=1, and is
  // silently dropped otherwise (no queueing). BUSY=0 and DONE=0 indicate IDLE.
  logic         START;
  logic         FIRST;
  logic [5:0]   I;
  logic [31:0]  W_IN;
  logic         BUSY;
  logic         DONE;
  logic [255:0] DIGEST;

  modport master (
    output START, FIRST, W_IN,
    input  I, BUSY, DONE, DIGEST
  );

  modport slave (
    input  START, FIRST, W_IN,
    output I, BUSY, DONE, DIGEST
  );
endinterface

// File: rtl/sha256_round.sv
// One SHA-256 round: combinational update of the eight working variables.
module sha256_round
  import sha256_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  input  logic [31:0] e,
  input  logic [31:0] f,
  input  logic [31:0] g,
  input  logic [31:0] h,
  input  logic [31:0] k,
  input  logic [31:0] w,
  output logic [31:0] a_next,
  output logic [31:0] b_next,
  output logic [31:0] c_next,
  output logic [31:0] d_next,
  output logic [31:0] e_next,
  output logic [31:0] f_next,
  output logic [31:0] g_next,
  output logic [31:0] h_next
);

  logic [31:0] t1;
  logic [31:0] t2;

  // All sums wrap mod 2^32 because every operand and result is 32 bits.
  always_comb begin
    t1 = h + big_sigma1(e) + ch(e, f, g) + k + w;
    t2 = big_sigma0(a) + maj(a, b, c);
  end

  assign a_next = t1 + t2;
  assign b_next = a;
  assign c_next = b;
  assign d_next = c;
  assign e_next = d + t1;
  assign f_next = e;
  assign g_next = f;
  assign h_next = g;

endmodule

// File: rtl/sha256_compress.sv
// SHA-256 compression engine: 64 rounds fed one schedule word per cycle, then
// the chaining add into H0..H7, which drive DIGEST directly.
module sha256_compress
  import sha256_pkg::*;
(
  input  logic                CLK,
  input  logic                RST_N,
  sha256_compress_if.slave    bus,
  output state_t              fsm_state
);

  state_t           state;
  logic [5:0]       counter;
  logic             busy;
  logic             done;
  logic [0:7][31:0] wv;
  logic [0:7][31:0] wv_next;
  logic [0:7][31:0] hreg;

  sha256_round u_round (
    .a      (wv[0]),
    .b      (wv[1]),
    .c      (wv[2]),
    .d      (wv[3]),
    .e      (wv[4]),
    .f      (wv[5]),
    .g      (wv[6]),
    .h      (wv[7]),
    .k      (K[counter]),
    .w      (bus.W_IN),
    .a_next (wv_next[0]),
    .b_next (wv_next[1]),
    .c_next (wv_next[2]),
    .d_next (wv_next[3]),
    .e_next (wv_next[4]),
    .f_next (wv_next[5]),
    .g_next (wv_next[6]),
    .h_next (wv_next[7])
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= ST_IDLE;
      counter <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wv      <= '0;
      hreg    <= IV;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.START) begin
            state   <= ST_ROUND;
            busy    <= 1'b1;
            counter <= '0;
            if (bus.FIRST) begin
              wv   <= IV;
              hreg <= IV;
            end else begin
              wv <= hreg;
            end
          end
        end
        ST_ROUND: begin
          wv <= wv_next;
          // Counter parks at 0 after round 63 so I reads 0 outside ROUND.
          if (counter == 6'd63) begin
            state   <= ST_ADD;
            counter <= '0;
          end else begin
            counter <= counter + 6'd1;
          end
        end
        ST_ADD: begin
          for (int j = 0; j < 8; j++) begin
            hreg[j] <= hreg[j] + wv[j];
          end
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.I      = counter;
  assign bus.BUSY   = busy;
  assign bus.DONE   = done;
  assign bus.DIGEST = hreg;
  assign fsm_state  = state;

endmodule
